// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the multi-cycle subtractor.
// The master issues operands and consumes results; the slave is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, zero, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, zero, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: d = a - b - bin, DIGIT bits per clock, LSB chunk first,
// with a registered borrow between chunks and flags published on completion.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_badParams
            $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_aMsb;
    logic             r_bMsb;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shadow;

    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;
    logic             r_done;

    logic [DIGIT-1:0] w_aChunk;
    logic [DIGIT-1:0] w_bChunk;
    logic [DIGIT-1:0] w_diff;
    logic [DIGIT:0]   w_bor;
    logic [WIDTH-1:0] w_result;

    // Operands shift right each busy cycle, so the active chunk is always the low DIGIT bits.
    assign w_aChunk = r_a[DIGIT-1:0];
    assign w_bChunk = r_b[DIGIT-1:0];
    assign w_bor[0] = r_borrow;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign w_diff[i]  = w_aChunk[i] ^ w_bChunk[i] ^ w_bor[i];
        assign w_bor[i+1] = (~w_aChunk[i] & w_bChunk[i])
                          | (~(w_aChunk[i] ^ w_bChunk[i]) & w_bor[i]);
    end

    // New chunk enters at the top; after N shifts the shadow holds the whole difference.
    assign w_result = (r_shadow >> DIGIT) | (WIDTH'(w_diff) << (WIDTH - DIGIT));

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_last      = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_aMsb   <= 1'b0;
            r_bMsb   <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= w_last;
            if (w_accept) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_aMsb   <= bus.a[WIDTH-1];
                r_bMsb   <= bus.b[WIDTH-1];
                r_borrow <= bus.bin;
                r_cnt    <= '0;
            end else if (r_state == ST_BUSY) begin
                r_a      <= r_a >> DIGIT;
                r_b      <= r_b >> DIGIT;
                r_borrow <= w_bor[DIGIT];
                r_shadow <= w_result;
                r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
                // Results become visible only once the final chunk lands.
                if (w_last) begin
                    r_d    <= w_result;
                    r_bout <= w_bor[DIGIT];
                    r_zero <= (w_result == '0);
                    r_ovf  <= (r_aMsb != r_bMsb) && (w_result[WIDTH-1] != r_aMsb);
                end
            end
        end
    end

    assign bus.busy = (r_state == ST_BUSY);
    assign bus.done = r_done;
    assign bus.d    = r_d;
    assign bus.bout = r_bout;
    assign bus.zero = r_zero;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised bench for serial_subtractor at DIGIT=4, 1 and 16 against an
// integer-arithmetic reference, plus handshake, back-to-back and abort cases.
module tb_serial_subtractor;
    localparam int W    = 16;
    localparam int NSEL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus4 ();
    serial_subtractor_if #(.WIDTH(W)) bus1 ();
    serial_subtractor_if #(.WIDTH(W)) bus16 ();

    serial_subtractor #(.WIDTH(W), .DIGIT(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    serial_subtractor #(.WIDTH(W), .DIGIT(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    serial_subtractor #(.WIDTH(W), .DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         bout;
        logic         zero;
        logic         ovf;
        logic [W-1:0] d;
    } obs_t;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         zero;
        logic         ovf;
    } res_t;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] prevD [NSEL];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int latOf(input int sel);
        case (sel)
            0:       return 4;
            1:       return 16;
            default: return 1;
        endcase
    endfunction

    // Reference: plain integer subtraction, unsigned for d/bout, signed range for ovf.
    function automatic res_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        res_t r;
        int   diff;
        int   sdiff;
        diff   = int'(a) - int'(b) - int'(bi);
        sdiff  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        r.d    = W'(diff);
        r.bout = (diff < 0);
        r.zero = (r.d == '0);
        r.ovf  = (sdiff > (1 << (W - 1)) - 1) || (sdiff < -(1 << (W - 1)));
        return r;
    endfunction

    task automatic driveIn(input int sel, input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        case (sel)
            0: begin bus4.start = s;  bus4.a = a;  bus4.b = b;  bus4.bin = bi;  end
            1: begin bus1.start = s;  bus1.a = a;  bus1.b = b;  bus1.bin = bi;  end
            default: begin bus16.start = s; bus16.a = a; bus16.b = b; bus16.bin = bi; end
        endcase
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        case (sel)
            0:       o = '{bus4.busy,  bus4.done,  bus4.bout,  bus4.zero,  bus4.ovf,  bus4.d};
            1:       o = '{bus1.busy,  bus1.done,  bus1.bout,  bus1.zero,  bus1.ovf,  bus1.d};
            default: o = '{bus16.busy, bus16.done, bus16.bout, bus16.zero, bus16.ovf, bus16.d};
        endcase
        return o;
    endfunction

    // One operation; inputs are scrambled (including start) while busy to show they are ignored.
    task automatic applyStimulus(input int sel, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        res_t exp;
        obs_t o;
        int   cyc;
        bit   seen;
        exp = refModel(a, b, bi);
        @(negedge clk);
        driveIn(sel, 1'b1, a, b, bi);
        @(posedge clk); #1;
        o = sample(sel);
        checkOutput("accept_busy", 32'(o.busy), 32'd1);
        checkOutput("accept_hold_d", 32'(o.d), 32'(prevD[sel]));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < latOf(sel) + 4) begin
            @(negedge clk);
            driveIn(sel, 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
            @(posedge clk); #1;
            cyc++;
            o = sample(sel);
            if (o.done) begin
                seen = 1'b1;
            end else begin
                checkOutput("busy_run", 32'(o.busy), 32'd1);
                checkOutput("busy_hold_d", 32'(o.d), 32'(prevD[sel]));
            end
        end
        checkOutput("latency", seen ? cyc : -1, latOf(sel));
        checkOutput("d", 32'(o.d), 32'(exp.d));
        checkOutput("bout", 32'(o.bout), 32'(exp.bout));
        checkOutput("zero", 32'(o.zero), 32'(exp.zero));
        checkOutput("ovf", 32'(o.ovf), 32'(exp.ovf));
        checkOutput("done_busy", 32'(o.busy), 32'd0);
        prevD[sel] = exp.d;
        @(negedge clk);
        driveIn(sel, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
        @(posedge clk); #1;
        o = sample(sel);
        checkOutput("done_pulse", 32'(o.done), 32'd0);
        checkOutput("idle_busy", 32'(o.busy), 32'd0);
        checkOutput("idle_hold_d", 32'(o.d), 32'(exp.d));
    endtask

    // Start held high on DIGIT=4: an op is accepted every 5 edges using the operands present then.
    task automatic heldHighTest();
        logic [W-1:0] opA [15];
        logic [W-1:0] opB [15];
        logic         opBin [15];
        obs_t         o;
        res_t         exp;
        @(negedge clk);
        for (int c = 0; c < 15; c++) begin
            opA[c]   = W'($urandom);
            opB[c]   = W'($urandom);
            opBin[c] = 1'($urandom);
            driveIn(0, 1'b1, opA[c], opB[c], opBin[c]);
            @(posedge clk); #1;
            o = sample(0);
            checkOutput("held_done", 32'(o.done), 32'((c % 5) == 4));
            if ((c % 5) == 4) begin
                exp = refModel(opA[c-4], opB[c-4], opBin[c-4]);
                checkOutput("held_d", 32'(o.d), 32'(exp.d));
                checkOutput("held_bout", 32'(o.bout), 32'(exp.bout));
                prevD[0] = exp.d;
            end
            @(negedge clk);
        end
        driveIn(0, 1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        o = sample(0);
        checkOutput("held_idle_busy", 32'(o.busy), 32'd0);
    endtask

    // Reset two cycles into an operation must abort it without a done pulse.
    task automatic resetAbortTest();
        obs_t o;
        @(negedge clk);
        driveIn(0, 1'b1, 16'h1234, 16'h0234, 1'b0);
        @(posedge clk);
        @(negedge clk);
        driveIn(0, 1'b0, 16'hFFFF, 16'h0001, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < NSEL; s++) begin
            checkOutput("abort_outputs", 32'(sample(s)), 32'd0);
            prevD[s] = '0;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            o = sample(0);
            checkOutput("abort_no_done", 32'({o.busy, o.done}), 32'd0);
        end
    endtask

    initial begin
        for (int s = 0; s < NSEL; s++) begin
            driveIn(s, 1'b0, '0, '0, 1'b0);
            prevD[s] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < NSEL; s++) checkOutput("reset_state", 32'(sample(s)), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 16'h1234, 16'h0234, 1'b0);
        applyStimulus(0, 16'h0000, 16'h0001, 1'b0);
        applyStimulus(0, 16'h8000, 16'h0001, 1'b0);
        applyStimulus(0, 16'h5555, 16'h5554, 1'b1);
        applyStimulus(0, 16'h0005, 16'h0005, 1'b1);
        applyStimulus(0, 16'h7FFF, 16'hFFFF, 1'b0);

        heldHighTest();
        resetAbortTest();
        applyStimulus(0, 16'h1234, 16'h0234, 1'b0);
        applyStimulus(0, 16'h0000, 16'h0000, 1'b0);

        for (int s = 1; s < NSEL; s++) begin
            applyStimulus(s, 16'h0000, 16'hFFFF, 1'b1);
            applyStimulus(s, 16'hFFFF, 16'hFFFF, 1'b0);
            applyStimulus(s, 16'h8000, 16'h0000, 1'b1);
        end
        for (int s = 0; s < NSEL; s++) begin
            for (int i = 0; i < 20; i++) applyStimulus(s, W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, parametrised subtractor: computes D = A - B - BIN for WIDTH-bit operands.
- Processes DIGIT bits per clock, LSB chunk first, with a registered borrow chain. This trades latency for area against the single-cycle half/full subtractor cells.
- Sits in the arithmetic datapath behind a start/done handshake.
- Also reports borrow-out, zero and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be at least 1.
- DIGIT, 4, bits subtracted per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT must equal 0, else elaboration error.
- N (localparam), WIDTH/DIGIT, number of processing cycles.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled when start is accepted.
- b  input  WIDTH  subtrahend; sampled when start is accepted.
- bin  input  1  borrow-in; sampled when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- d  output  WIDTH  difference (a - b - bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out; 1 iff a < b + bin.
- zero  output  1  1 iff d == 0.
- ovf  output  1  two's-complement overflow: (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]).

Behaviour:
- Reset is the single clock and reset as decided: one clock; reset is synchronous and active-high.
  - rst high at an edge: state=IDLE; busy, done, d, bout, zero, ovf all 0; chunk counter 0; internal operand and borrow registers cleared.
  - rst has priority over all other inputs.
- States: IDLE, BUSY.
- IDLE:
  - If start=1 at edge t, latch a, b and bin, clear the counter, go to BUSY. busy=1 from edge t.
  - start=0: remain in IDLE; outputs hold.
- BUSY, cycle k = 0..N-1:
  - Subtract chunk k: a[k*DIGIT +: DIGIT] - b[k*DIGIT +: DIGIT] - borrow_reg, using a DIGIT-wide ripple of full-subtractor cells.
  - Write the chunk result into d's shadow register; borrow_reg <= chunk borrow-out; counter increments.
  - borrow_reg is initialised to bin.
- Completion, at edge t+N (last chunk written):
  - State returns to IDLE, busy=0, done=1 for exactly one cycle.
  - d, bout, zero and ovf update at this edge from the complete result and hold until the next completion.
  - During BUSY, the d output holds the previous result; the partial result is not visible.
- Latency: start accepted at edge t gives done high in the cycle after edge t+N. DIGIT=WIDTH gives 1 cycle.
- start while BUSY is ignored, with no queueing. a, b and bin changing during BUSY have no effect.
- start=1 in the done cycle: state is IDLE, so it is accepted at the next edge. Back-to-back throughput is one op per N+1 cycles.
- rst during BUSY aborts the operation: no done pulse, outputs cleared to 0.
- Counter wrap: the counter never exceeds N-1; no wrap behaviour is exposed.
- Arithmetic: bout equals the final borrow_reg. zero is computed on the full WIDTH-bit result. ovf uses the latched a and b MSBs.

Test Plan:
All cases use WIDTH=16, DIGIT=4 (N=4) unless noted.
- a=0x1234, b=0x0234, bin=0, start pulse at edge 0 -> done high after edge 4 only; d=0x1000, bout=0, zero=0, ovf=0; busy high in cycles 0..3.
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1, zero=0, ovf=0. Then a=0x8000, b=0x0001 -> d=0x7FFF, bout=0, ovf=1.
- a=0x5555, b=0x5554, bin=1 -> d=0x0000, zero=1, bout=0, ovf=0. Then a=0x0005, b=0x0005, bin=1 -> d=0xFFFF, bout=1.
- start held high continuously with changing operands -> done every 5 cycles; operands are sampled only at acceptance edges; start pulses mid-BUSY do not alter the result.
- Issue 0x1234-0x0234, assert rst after 2 BUSY cycles -> no done; all outputs 0; busy=0. Next start yields a correct result with no stale borrow.
- Sweep DIGIT=1 (N=16) and DIGIT=16 (N=1) with random operands against a reference a-b-bin model -> d, bout, zero and ovf match, with latency exactly N.
